// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's control inputs, instruction-memory bus and
// IF/ID pipeline register outputs.
interface fetch_stage_if #(
    parameter int CNT_W = 16
);
    logic [31:0]      entryPoint;
    logic             INT;
    logic             stall;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [31:0]      imem_addr;
    logic [31:0]      imem_rdata;
    logic [31:0]      ins;
    logic [31:0]      pc_out;
    logic [31:0]      pcp4;
    logic             valid;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        input  entryPoint, INT, stall, redirect, redirect_pc, imem_rdata,
        output imem_addr, ins, pc_out, pcp4, valid, fetch_cnt
    );

    modport slave (
        output entryPoint, INT, stall, redirect, redirect_pc, imem_rdata,
        input  imem_addr, ins, pc_out, pcp4, valid, fetch_cnt
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address
// and holds the IF/ID register. INT (re)starts fetch, redirect re-steers, stall freezes.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter int          CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    fetch_stage_if.master      bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    state_t           state_r, state_s;
    logic [31:0]      pc_r, pc_s;
    logic [31:0]      ins_r, ins_s;
    logic [31:0]      pc_out_r, pc_out_s;
    logic [31:0]      pcp4_r, pcp4_s;
    logic             valid_r, valid_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;

    // Next-state and next-register computation; priority INT > redirect > stall > advance.
    always_comb begin
        state_s  = state_r;
        pc_s     = pc_r;
        ins_s    = ins_r;
        pc_out_s = pc_out_r;
        pcp4_s   = pcp4_r;
        valid_s  = valid_r;
        cnt_s    = cnt_r;
        if (bus.INT) begin
            pc_s    = bus.entryPoint & ALIGN_MASK;
            ins_s   = 32'd0;
            valid_s = 1'b0;
            state_s = RUN;
        end else begin
            case (state_r)
                IDLE: begin
                    state_s = IDLE;
                end
                RUN: begin
                    if (bus.redirect) begin
                        // Wrong-path word at the old PC is dropped as a bubble.
                        pc_s    = bus.redirect_pc & ALIGN_MASK;
                        ins_s   = 32'd0;
                        valid_s = 1'b0;
                    end else if (bus.stall) begin
                        pc_s    = pc_r;
                        valid_s = valid_r;
                    end else begin
                        ins_s    = bus.imem_rdata;
                        pc_out_s = pc_r;
                        pcp4_s   = pc_r + 32'd4;
                        valid_s  = 1'b1;
                        pc_s     = pc_r + 32'd4;
                        cnt_s    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end
    end

    // State, PC and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            pc_r     <= RESET_PC;
            ins_r    <= 32'd0;
            pc_out_r <= 32'd0;
            pcp4_r   <= 32'd0;
            valid_r  <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            ins_r    <= ins_s;
            pc_out_r <= pc_out_s;
            pcp4_r   <= pcp4_s;
            valid_r  <= valid_s;
            cnt_r    <= cnt_s;
        end
    end

    assign bus.imem_addr = pc_r;
    assign bus.ins       = ins_r;
    assign bus.pc_out    = pc_out_r;
    assign bus.pcp4      = pcp4_r;
    assign bus.valid     = valid_r;
    assign bus.fetch_cnt = cnt_r;
endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage (CNT_W=4 so counter wrap is reachable).
module tb_fetch_stage;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   nerr = 0;
    int   nchk = 0;

    fetch_stage_if #(.CNT_W(CW)) bus ();

    fetch_stage #(.RESET_PC(32'd0), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a fixed function of the word address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    assign bus.imem_rdata = memf(bus.imem_addr);

    typedef struct {
        logic        int_i;
        logic [31:0] ep;
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic [3:0]  e_cnt;
        logic [31:0] e_addr;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic i, input logic [31:0] ep, input logic st,
                                input logic rd, input logic [31:0] rpc, input logic ev,
                                input logic [31:0] epc, input logic [31:0] ep4,
                                input logic [3:0] ec, input logic [31:0] ea);
        vec_t v;
        v.int_i = i; v.ep = ep; v.st = st; v.rd = rd; v.rpc = rpc;
        v.e_valid = ev; v.e_pc = epc; v.e_p4 = ep4; v.e_cnt = ec; v.e_addr = ea;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic ev, input logic [31:0] epc,
                           input logic [31:0] ep4, input logic [3:0] ec,
                           input logic [31:0] ea);
        chk("valid", idx, {31'd0, bus.valid}, {31'd0, ev});
        chk("ins", idx, bus.ins, ev ? memf(epc) : 32'd0);
        chk("pc_out", idx, bus.pc_out, epc);
        chk("pcp4", idx, bus.pcp4, ep4);
        chk("fetch_cnt", idx, {28'd0, bus.fetch_cnt}, {28'd0, ec});
        chk("imem_addr", idx, bus.imem_addr, ea);
    endtask

    task automatic drive(input logic i, input logic [31:0] ep, input logic st,
                         input logic rd, input logic [31:0] rpc);
        bus.INT = i; bus.entryPoint = ep; bus.stall = st;
        bus.redirect = rd; bus.redirect_pc = rpc;
    endtask

    initial begin
        //                int  entry          st    rd    rpc      valid  pc_out         pcp4           cnt    addr
        tbl[0]  = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b0, 32'd0,         32'd0,         4'd0, 32'd0);
        tbl[1]  = mk(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,   1'b0, 32'd0,         32'd0,         4'd0, 32'd0);
        tbl[2]  = mk(1'b0, 32'd0,        1'b0, 1'b1, 32'd500, 1'b0, 32'd0,         32'd0,         4'd0, 32'd0);
        tbl[3]  = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b0, 32'd0,         32'd0,         4'd0, 32'd0);
        tbl[4]  = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b0, 32'd0,         32'd0,         4'd0, 32'd0);
        tbl[5]  = mk(1'b1, 32'd128,      1'b0, 1'b0, 32'd0,   1'b0, 32'd0,         32'd0,         4'd0, 32'd128);
        tbl[6]  = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b1, 32'd128,       32'd132,       4'd1, 32'd132);
        tbl[7]  = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b1, 32'd132,       32'd136,       4'd2, 32'd136);
        tbl[8]  = mk(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,   1'b1, 32'd132,       32'd136,       4'd2, 32'd136);
        tbl[9]  = mk(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,   1'b1, 32'd132,       32'd136,       4'd2, 32'd136);
        tbl[10] = mk(1'b0, 32'd0,        1'b1, 1'b0, 32'd0,   1'b1, 32'd132,       32'd136,       4'd2, 32'd136);
        tbl[11] = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b1, 32'd136,       32'd140,       4'd3, 32'd140);
        tbl[12] = mk(1'b0, 32'd0,        1'b0, 1'b1, 32'd200, 1'b0, 32'd136,       32'd140,       4'd3, 32'd200);
        tbl[13] = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b1, 32'd200,       32'd204,       4'd4, 32'd204);
        tbl[14] = mk(1'b0, 32'd0,        1'b1, 1'b1, 32'd203, 1'b0, 32'd200,       32'd204,       4'd4, 32'd200);
        tbl[15] = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b1, 32'd200,       32'd204,       4'd5, 32'd204);
        tbl[16] = mk(1'b1, 32'hFFFFFFF9, 1'b1, 1'b1, 32'd300, 1'b0, 32'd200,       32'd204,       4'd5, 32'hFFFFFFF8);
        tbl[17] = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b1, 32'hFFFFFFF8,  32'hFFFFFFFC,  4'd6, 32'hFFFFFFFC);
        tbl[18] = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b1, 32'hFFFFFFFC,  32'd0,         4'd7, 32'd0);
        tbl[19] = mk(1'b0, 32'd0,        1'b0, 1'b0, 32'd0,   1'b1, 32'd0,         32'd4,         4'd8, 32'd4);

        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        #1;
        chk_all(100, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].int_i, tbl[i].ep, tbl[i].st, tbl[i].rd, tbl[i].rpc);
            @(posedge clk);
            #1;
            chk_all(i, tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_p4, tbl[i].e_cnt, tbl[i].e_addr);
        end

        // Asynchronous reset between edges while valid=1.
        #2 rst = 1'b1;
        #1;
        chk_all(200, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // After release the stage must be idle: stall/redirect have no effect.
        drive(1'b0, 32'd0, 1'b0, 1'b1, 32'd400);
        @(posedge clk);
        #1;
        chk_all(201, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0);

        drive(1'b1, 32'd64, 1'b0, 1'b0, 32'd0);
        @(posedge clk);
        #1;
        chk_all(202, 1'b0, 32'd0, 32'd0, 4'd0, 32'd64);

        // 17 valid fetches from a cleared counter wrap a 4-bit count to 1.
        drive(1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
        for (int k = 0; k < 17; k++) begin
            @(posedge clk);
            #1;
            chk_all(300 + k, 1'b1, 32'd64 + 32'(4 * k), 32'd68 + 32'(4 * k),
                    4'((k + 1) % 16), 32'd68 + 32'(4 * k));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage pipeline CPU: owns the program counter, drives the instruction-memory address, and holds the IF/ID pipeline register consumed by decode. It sits directly upstream of the decode stage inside the chip. The `INT` pulse loads `entryPoint`, hazard-unit stalls freeze it, and EX-stage branch/jump redirects re-steer and flush it.

## Interface
- `RESET_PC`, default 32'd0: PC value held after reset.
- `CNT_W`, default 16: width of the fetch counter.
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst`  in  1  : asynchronous, active-high reset.
- `entryPoint`  in  32 : program start address, loaded when `INT`=1.
- `INT`  in  1  : load `entryPoint` and start or restart fetching.
- `stall`  in  1  : hazard hold; freezes PC and IF/ID.
- `redirect`  in  1  : taken branch/jump from EX.
- `redirect_pc`  in  32 : redirect target.
- `imem_addr`  out 32 : instruction-memory address; always equals PC (combinational).
- `imem_rdata`  in  32 : instruction word; combinational read of `imem_addr`, same cycle.
- `ins`  out 32 : IF/ID instruction.
- `pc_out`  out 32 : IF/ID PC of `ins`.
- `pcp4`  out 32 : IF/ID `pc_out`+4.
- `valid`  out 1  : IF/ID holds a real instruction; 0 means bubble, and `ins`=0 (NOP).
- `fetch_cnt`  out CNT_W : count of instructions latched into IF/ID with `valid`=1.

## Operation
- States are IDLE and RUN. Reset enters IDLE. `INT`=1 moves to RUN from either state. RUN has no exit except `rst`.
- Edge priority: `rst` > `INT` > `redirect` > `stall` > normal advance.
- `INT` edge, in any state:
  - PC <= {entryPoint[31:2],2'b00}.
  - IF/ID <= bubble: `ins`=0, `valid`=0; `pc_out` and `pcp4` unchanged.
  - State <= RUN.
- IDLE without `INT`: PC and IF/ID hold; `stall` and `redirect` are ignored.
- RUN, `redirect`=1, regardless of `stall`:
  - PC <= {redirect_pc[31:2],2'b00}.
  - IF/ID <= bubble. The wrong-path instruction at the old PC is discarded.
- RUN, `stall`=1, `redirect`=0: PC, IF/ID and `fetch_cnt` all hold.
- RUN, normal advance:
  - `ins` <= `imem_rdata`, `pc_out` <= PC, `pcp4` <= PC+4, `valid` <= 1.
  - PC <= PC+4.
  - `fetch_cnt` <= `fetch_cnt`+1.
- Arithmetic and width rules:
  - PC+4 is modulo 2^32; 32'hFFFFFFFC advances to 0.
  - `fetch_cnt` wraps from 2^CNT_W−1 to 0.
  - Low two bits of loaded addresses are forced to 0.
  - `INT` does not clear `fetch_cnt`; only `rst` does.

## Timing
- Reset values, asserted asynchronously as soon as `rst` rises, without waiting for a clock edge:
  - PC = `imem_addr` = RESET_PC.
  - `ins`=0, `pc_out`=0, `pcp4`=0, `valid`=0, `fetch_cnt`=0.
  - State = IDLE.
- `rst` mid-run: all of the above immediately; the next edge after deassertion sees IDLE.
- Latency from `INT` to the first instruction:
  - Edge E0 (`INT`=1) loads PC.
  - Edge E1 latches mem[entryPoint] with `valid`=1.
  - One instruction per edge thereafter.
- Redirect sampled at edge Ek: one bubble appears at Ek, and the target instruction appears at Ek+1.
- Stall is level-sensitive. N stalled edges delay the stream by exactly N cycles, with no loss or duplication.
- `imem_addr` changes only after an edge or on `rst`; it is never combinationally dependent on `redirect`.

## Test plan
- Reset then idle: `rst`=1 pulse, 5 edges without `INT` -> `imem_addr`=0, `valid`=0, `ins`=0, `fetch_cnt`=0 throughout.
- Entry load: `entryPoint`=128, `INT`=1 for one edge, memory holds words at 128,132,136 -> following edges show `pc_out`=128,132,136 with matching `ins`, `pcp4`=132,136,140, `fetch_cnt`=1,2,3.
- Stall: `stall`=1 for 3 edges while `pc_out`=132 -> `ins`, `pc_out` and `fetch_cnt` frozen; after release, 136 follows with no duplicate.
- Redirect: `redirect`=1, `redirect_pc`=200 at the edge after `pc_out`=136 -> next edge `valid`=0, `ins`=0; the edge after gives `pc_out`=200. Repeat with `stall`=1 and `redirect_pc`=203 -> redirect wins, PC=200.
- Wrap and alignment: `entryPoint`=32'hFFFFFFF9 -> first `pc_out`=32'hFFFFFFF8, then 32'hFFFFFFFC, then 0. With CNT_W=4, 17 valid fetches -> `fetch_cnt`=1.
- Async reset mid-run: `rst` asserted between edges with `valid`=1 -> outputs reach reset values before the next edge; after release, a new `INT` with `entryPoint`=64 restarts at 64.
